// File: rtl/ifetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD handshake to instruction memory with sticky fault flags.
// Define IFETCH_LASTHIT_EN to add a one-entry last-fetch buffer that skips memory on a repeat fetch.
module ifetch_unit (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [15:0] immd16,
  output logic [25:0] immd26,
  output logic        pc_stall,
  output logic        misalign,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic        pc_aligned;
  logic        hit;
  logic [31:0] hit_data;

  assign pc_aligned = (pc[1:0] == 2'b00);

`ifdef IFETCH_LASTHIT_EN
  logic [31:0] tag_q;
  logic [31:0] data_q;
  logic        buf_valid_q;

  // Refilled only by fetches that actually went to memory.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      tag_q       <= 32'h0;
      data_q      <= 32'h0;
      buf_valid_q <= 1'b0;
    end else if (state_q == StReq && imem_ack) begin
      tag_q       <= addr_q;
      data_q      <= imem_rdata;
      buf_valid_q <= 1'b1;
    end
  end

  assign hit      = buf_valid_q && (pc == tag_q);
  assign hit_data = data_q;
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    wait_d     = wait_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StIdle, StHold: begin
        state_d = StIdle;
        if (fetch_en) begin
          if (!pc_aligned) begin
            misalign_d = 1'b1;
          end else if (hit) begin
            state_d = StHold;
            instr_d = hit_data;
          end else begin
            state_d = StReq;
            addr_d  = pc;
            wait_d  = 8'd0;
          end
        end
      end
      StReq: begin
        // fetch_en is deliberately ignored here: an issued request always completes or times out.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end else if (wait_q == 8'd255) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      addr_q     <= 32'h0;
      instr_q    <= 32'h0;
      wait_q     <= 8'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      wait_q     <= wait_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  // Decoded straight from the state register so reset drops the request without a clock edge.
  assign imem_req     = (state_q == StReq);
  assign instr_valid  = (state_q == StHold);
  assign pc_stall     = (state_q != StHold);
  assign imem_addr    = addr_q;
  assign instr        = instr_q;
  assign opcode       = instr_q[31:26];
  assign immd16       = instr_q[15:0];
  assign immd26       = instr_q[25:0];
  assign misalign     = misalign_q;
  assign imem_timeout = timeout_q;

endmodule
